// File: rtl/aes_key_expand_multi.sv
// Word-serial AES-128/192/256 key schedule engine holding NUM_SLOTS expanded schedules behind a registered round-key read port.
// Define AES_KEY_DECRYPT_EN to enable equivalent-inverse-cipher round-key reads via rd_inv.
//
// state | meaning
// IDLE  | waiting for start; read port serves stored schedules
// GEN   | writing one schedule word per cycle into slot_q
module aes_key_expand_multi #(
    parameter int NUM_SLOTS = 2,
    parameter int SLOT_W    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           key_len,
    input  logic [255:0]         key_in,
    input  logic [SLOT_W-1:0]    slot_in,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [NUM_SLOTS-1:0] slot_valid,
    input  logic                 rd_en,
    input  logic [SLOT_W-1:0]    rd_slot,
    input  logic [3:0]           rd_round,
    input  logic                 rd_inv,
    output logic [127:0]         rd_data
);
    typedef enum logic {IDLE, GEN} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as x^254 (multiplicative inverse, 0 -> 0) followed by the AES affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

`ifdef AES_KEY_DECRYPT_EN
    function automatic logic [31:0] inv_mix(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction
`else
    logic unused_rd_inv;
    assign unused_rd_inv = rd_inv;
`endif

    state_t                      state_q, state_d;
    logic [31:0]                 mem [NUM_SLOTS][60];
    logic [7:0][31:0]            win_q;     // win_q[0] = w[i-1], win_q[Nk-1] = w[i-Nk]
    logic [7:0][31:0]            key_win;
    logic [NUM_SLOTS-1:0][1:0]   slot_len_q;
    logic [1:0]                  len_q;
    logic [SLOT_W-1:0]           slot_q;
    logic [5:0]                  i_q;
    logic [2:0]                  phase_q;
    logic [7:0]                  rcon_q;
    logic                        accept, reject, last_word;
    logic [3:0]                  nk, nk_in;
    logic [5:0]                  ntot;
    logic [31:0]                 w_prev, w_back, temp, new_word;
    logic [1:0]                  rd_len;
    logic [3:0]                  rd_nr, key_round;
    logic [5:0]                  base;
    logic                        rd_ok;
    logic [127:0]                rd_word, rd_next;

    always_comb begin
        accept  = 1'b0;
        reject  = 1'b0;
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept = (key_len != 2'd3) && (32'(slot_in) < NUM_SLOTS);
                    reject = !accept;
                end
                if (accept) state_d = GEN;
            end
            GEN:     if (last_word) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        nk_in     = 4'd4 + {1'b0, key_len, 1'b0};
        key_win   = key_in >> {4'd8 - nk_in, 5'd0};
        nk        = 4'd4 + {1'b0, len_q, 1'b0};
        ntot      = 6'd44 + {1'b0, len_q, 3'b000};
        w_prev    = win_q[0];
        w_back    = win_q[3'(nk - 4'd1)];
        temp      = w_prev;
        if (phase_q == 3'd0)
            temp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon_q, 24'h000000};
        else if (len_q == 2'd2 && phase_q == 3'd4)
            temp = sub_word(w_prev);
        new_word  = w_back ^ temp;
        last_word = (i_q == ntot - 6'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            slot_valid <= '0;
            slot_len_q <= '0;
            len_q      <= 2'd0;
            slot_q     <= '0;
            i_q        <= 6'd0;
            phase_q    <= 3'd0;
            rcon_q     <= 8'h01;
            rd_data    <= '0;
        end else begin
            state_q <= state_d;
            done    <= 1'b0;
            err     <= reject;
            if (rd_en) rd_data <= rd_next;
            if (accept) begin
                len_q               <= key_len;
                slot_q              <= slot_in;
                slot_valid[slot_in] <= 1'b0;
                i_q                 <= {2'b00, nk_in};
                phase_q             <= 3'd0;
                rcon_q              <= 8'h01;
                busy                <= 1'b1;
            end else if (state_q == GEN) begin
                i_q     <= i_q + 6'd1;
                phase_q <= ({1'b0, phase_q} == nk - 4'd1) ? 3'd0 : phase_q + 3'd1;
                if (phase_q == 3'd0) rcon_q <= xtime(rcon_q);
                if (last_word) begin
                    busy               <= 1'b0;
                    done               <= 1'b1;
                    slot_valid[slot_q] <= 1'b1;
                    slot_len_q[slot_q] <= len_q;
                end
            end
        end
    end

    // Schedule storage is not reset; slot_valid gates every read.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < 8; k++) mem[slot_in][k] <= key_in[255 - 32*k -: 32];
            win_q <= key_win;
        end else if (state_q == GEN) begin
            mem[slot_q][i_q] <= new_word;
            win_q            <= {win_q[6:0], new_word};
        end
    end

    always_comb begin
        rd_len    = slot_len_q[rd_slot];
        rd_nr     = 4'd10 + {1'b0, rd_len, 1'b0};
        rd_ok     = (32'(rd_slot) < NUM_SLOTS) && slot_valid[rd_slot] && (rd_round <= rd_nr);
        key_round = rd_round;
`ifdef AES_KEY_DECRYPT_EN
        if (rd_inv) key_round = rd_nr - rd_round;
`endif
        base    = {key_round, 2'b00};
        rd_word = {mem[rd_slot][base], mem[rd_slot][base + 6'd1],
                   mem[rd_slot][base + 6'd2], mem[rd_slot][base + 6'd3]};
`ifdef AES_KEY_DECRYPT_EN
        if (rd_inv && rd_round != 4'd0 && rd_round != rd_nr)
            rd_word = {inv_mix(rd_word[127:96]), inv_mix(rd_word[95:64]),
                       inv_mix(rd_word[63:32]), inv_mix(rd_word[31:0])};
`endif
        rd_next = rd_ok ? rd_word : '0;
    end
endmodule
